// File: rtl/fetch_ctrl.sv
// fetch_ctrl: stall/flush sequencer for the fetch stage with a post-reset boot hold and a fetch-wait watchdog.
// Optional build macro FETCH_CTRL_PERF_EN enables the stall_cnt/flush_cnt performance counters.
module fetch_ctrl #(
  parameter int unsigned BOOT_CYCLES = 2,
  parameter int unsigned TIMEOUT     = 64,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic        imem_ready,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        fetch_timeout,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  localparam int unsigned      BOOT_EFF  = (BOOT_CYCLES == 0) ? 1 : BOOT_CYCLES;
  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_EFF - 1);
  localparam logic [CNT_W-1:0] WAIT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] boot_cnt;
  logic [CNT_W-1:0] wait_cnt;
  logic             lu;
  logic             rd;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v,
                                                   input logic [CNT_W-1:0] lim);
    return (v >= lim) ? v : v + CNT_W'(1);
  endfunction

  // x0 is hardwired, so a load targeting it can never create a hazard.
  assign lu = ex_mem_read && (ex_rd != 5'd0) &&
              ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));
  assign rd = branch_taken || jump;

  always_comb begin
    pc_write    = 1'b0;
    if_id_write = 1'b0;
    if_id_flush = 1'b1;
    id_ex_flush = 1'b1;
    state_d     = state_q;
    if (rst) begin
      state_d = BOOT;
    end else if (state_q == BOOT) begin
      if (boot_cnt >= BOOT_LAST) state_d = RUN;
    end else if (rd) begin
      // Redirect beats a load-use stall: the stalled instruction is wrong-path.
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      if (imem_ready) state_d = RUN;
      else            state_d = MEM_WAIT;
    end else if (lu) begin
      if_id_flush = 1'b0;
    end else if (!imem_ready) begin
      if_id_write = 1'b1;
      id_ex_flush = 1'b0;
      state_d     = MEM_WAIT;
    end else begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      state_d     = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BOOT;
      boot_cnt      <= '0;
      wait_cnt      <= '0;
      fetch_timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == BOOT) boot_cnt <= sat_inc_cnt(boot_cnt, BOOT_LAST);
      if (state_q == MEM_WAIT) begin
        if (state_d != MEM_WAIT)  wait_cnt <= '0;
        else if (!imem_ready)     wait_cnt <= sat_inc_cnt(wait_cnt, WAIT_MAX);
        // Sticky: the pipeline keeps waiting, only rst clears the flag.
        if (!imem_ready && (wait_cnt == WAIT_LAST)) fetch_timeout <= 1'b1;
      end
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  logic        active;
  logic        stall_ev;
  logic        flush_ev;
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign active   = !rst && (state_q != BOOT);
  assign flush_ev = active && rd;
  assign stall_ev = active && !rd && (lu || !imem_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_ev) stall_q <= sat_inc32(stall_q);
      if (flush_ev) flush_q <= sat_inc32(flush_q);
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed test-plan sequences followed by randomized traffic.
module tb_fetch_ctrl;
  localparam int BOOT_CYCLES = 2;
  localparam int TIMEOUT     = 4;
  localparam int CNT_W       = 8;
  localparam int BOOT_EFF    = (BOOT_CYCLES == 0) ? 1 : BOOT_CYCLES;
`ifdef FETCH_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic        id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, ex_mem_read = 1'b0;
  logic        branch_taken = 1'b0, jump = 1'b0, imem_ready = 1'b1;
  logic        pc_write, if_id_write, if_id_flush, id_ex_flush, fetch_timeout;
  logic [31:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  fetch_ctrl #(.BOOT_CYCLES(BOOT_CYCLES), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .branch_taken(branch_taken), .jump(jump), .imem_ready(imem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .fetch_timeout(fetch_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct {
    logic [3:0]  ctl;   // {pc_write, if_id_write, if_id_flush, id_ex_flush}
    logic        to;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: age since reset, whether a fetch is outstanding, and event tallies.
  bit     m_known   = 1'b0;
  int     m_age     = 0;
  bit     m_waiting = 1'b0;
  int     m_waited  = 0;
  bit     m_to      = 1'b0;
  longint m_stall   = 0;
  longint m_flush   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input bit r, input logic [4:0] rs1, input logic [4:0] rs2,
                       input bit u1, input bit u2, input bit mr, input logic [4:0] erd,
                       input bit bt, input bit jp, input bit ir);
    exp_t e;
    bit   hz, redir, was_wait;
    rst = r; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    ex_mem_read = mr; ex_rd = erd; branch_taken = bt; jump = jp; imem_ready = ir;

    hz    = mr && (erd != 0) && ((u1 && rs1 == erd) || (u2 && rs2 == erd));
    redir = bt || jp;
    e.to  = m_to;
    e.sc  = PERF ? m_stall[31:0] : 32'd0;
    e.fc  = PERF ? m_flush[31:0] : 32'd0;
    if (r || m_age < BOOT_EFF) e.ctl = 4'b0011;
    else if (redir)            e.ctl = 4'b1111;
    else if (hz)               e.ctl = 4'b0001;
    else if (!ir)              e.ctl = 4'b0110;
    else                       e.ctl = 4'b1100;
    if (m_known) sb.push_back(e);

    if (r) begin
      m_known = 1'b1; m_age = 0; m_waiting = 1'b0; m_waited = 0;
      m_to = 1'b0; m_stall = 0; m_flush = 0;
    end else if (m_age < BOOT_EFF) begin
      m_age++;
    end else begin
      was_wait = m_waiting;
      if (redir || !hz) m_waiting = !ir;
      if (was_wait && !ir) begin
        if (m_waited == TIMEOUT - 1) m_to = 1'b1;
        if (m_waited < TIMEOUT) m_waited++;
      end
      if (!m_waiting) m_waited = 0;
      if (redir) begin
        if (m_flush < 64'hFFFF_FFFF) m_flush++;
      end else if (hz || !ir) begin
        if (m_stall < 64'hFFFF_FFFF) m_stall++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit r, input bit ir);
    drive(r, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, ir);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("ctrl", {28'd0, pc_write, if_id_write, if_id_flush, id_ex_flush}, {28'd0, e.ctl});
      chk("fetch_timeout", {31'd0, fetch_timeout}, {31'd0, e.to});
      chk("stall_cnt", stall_cnt, e.sc);
      chk("flush_cnt", flush_cnt, e.fc);
    end
  end

  initial begin
    bit lowbias;
    // Reset held 3 cycles, then boot hold and normal fetch.
    repeat (3) idle(1'b1, 1'b1);
    repeat (4) idle(1'b0, 1'b1);
    // Load-use on rs2, then the same pattern against x0.
    drive(1'b0, 5'd1, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
    idle(1'b0, 1'b1);
    drive(1'b0, 5'd1, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    // Redirect over load-use, and branch+jump together.
    drive(1'b0, 5'd5, 5'd2, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
    idle(1'b0, 1'b1);
    // Memory wait of 3 cycles, then return to RUN.
    repeat (3) idle(1'b0, 1'b0);
    repeat (2) idle(1'b0, 1'b1);
    // Watchdog: long wait, flag stays after memory returns.
    repeat (8) idle(1'b0, 1'b0);
    repeat (3) idle(1'b0, 1'b1);
    // Reset mid-wait.
    repeat (2) idle(1'b0, 1'b0);
    idle(1'b1, 1'b0);
    repeat (4) idle(1'b0, 1'b1);
    // Randomized traffic with phases biased toward memory stalls.
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) lowbias = ($urandom_range(0, 1) == 1);
      drive($urandom_range(0, 99) == 0,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) == 0, 5'($urandom_range(0, 3)),
            $urandom_range(0, 11) == 0, $urandom_range(0, 15) == 0,
            lowbias ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 8));
    end
    @(negedge clk);
    #1;
    chk("scoreboard_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequencing controller for the pipelined fetch stage.
- Drives pc_write, if_id_write, if_id_flush and an ID/EX bubble request from four sources: load-use hazards, branch/jump redirects, instruction-memory wait states and a post-reset boot hold.
- Sits beside the IF stage and hazard paths. Owns all fetch stall/flush decisions; the stage itself makes none.
- Adds a fetch-wait watchdog.

Parameters:
- BOOT_CYCLES, 2: cycles after reset release during which fetch is held.
- TIMEOUT, 64: consecutive MEM_WAIT cycles before fetch_timeout is set.
- CNT_W, 8: width of the boot and wait counters; must hold max(BOOT_CYCLES, TIMEOUT).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs1  in  5  rs1 of instruction in ID.
- id_rs2  in  5  rs2 of instruction in ID.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rd  in  5  destination register of EX instruction.
- branch_taken  in  1  taken branch resolved in EX this cycle.
- jump  in  1  jump resolved in EX this cycle.
- imem_ready  in  1  instruction memory data valid this cycle.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID register load enable.
- if_id_flush  out  1  IF/ID register clear (bubble into ID).
- id_ex_flush  out  1  ID/EX bubble request.
- fetch_timeout  out  1  sticky watchdog flag.
- stall_cnt  out  32  load-use plus memory-wait stall cycles (see optional feature).
- flush_cnt  out  32  redirect count (see optional feature).

Behaviour:
- Single clock domain: clk, one clock; rst synchronous, active-high. All state updates on rising clk.
- Outputs are combinational from state and inputs. No added latency: the decision applies at the edge ending the current cycle.
- States: BOOT, RUN, MEM_WAIT.

Reset (rst=1):
- State -> BOOT; boot_cnt=0, wait_cnt=0, fetch_timeout=0, counters=0.
- During reset, and in BOOT: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1.
- rst asserted in any state, mid-stall or mid-wait, returns to BOOT the next edge.

BOOT:
- boot_cnt increments each cycle.
- At boot_cnt==BOOT_CYCLES-1 -> RUN.
- BOOT_CYCLES=0 is treated as 1.
- All other inputs are ignored in BOOT.

Load-use hazard, lu:
- lu = ex_mem_read & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).

Redirect, rd:
- rd = branch_taken | jump.

RUN/MEM_WAIT output priority (first match wins):
1. rd: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_flush=1. Wins over lu, because the stalled instruction is wrong-path. Wins regardless of imem_ready; the PC loads the target and the abandoned fetch is discarded. Next state is RUN if imem_ready=1, else MEM_WAIT.
2. lu: pc_write=0, if_id_write=0, if_id_flush=0, id_ex_flush=1. State is unchanged; a wait in progress keeps counting.
3. !imem_ready: pc_write=0, if_id_write=1, if_id_flush=1, id_ex_flush=0. State -> MEM_WAIT.
4. Otherwise: pc_write=1, if_id_write=1, flushes 0. State -> RUN.

Wait counter:
- wait_cnt increments in MEM_WAIT each cycle imem_ready=0, saturating at TIMEOUT.
- wait_cnt clears on leaving MEM_WAIT.
- At wait_cnt==TIMEOUT-1 with imem_ready=0, fetch_timeout sets.
- fetch_timeout stays set until rst; the pipeline keeps waiting.

Simultaneous-event rules:
- branch_taken and jump together: treated as a single redirect; flush_cnt counts +1.
- lu with ex_rd==0: never a stall.

Optional Feature:
- Macro: FETCH_CTRL_PERF_EN.

With FETCH_CTRL_PERF_EN defined:
- stall_cnt increments by 1 each RUN/MEM_WAIT cycle where priority 2 or 3 applies.
- flush_cnt increments by 1 each cycle where rd applies.
- Both counters saturate at 0xFFFFFFFF, clear on rst, and do not count in BOOT.

Without the macro:
- Both ports remain present and are tied to 0.
- No counter flops are synthesized.

Test Plan:
- Reset, BOOT hold: rst high 3 cycles, then low, imem_ready=1. Expect pc_write=0 and if_id_flush=1 for 2 cycles after release; pc_write=1 on the 3rd cycle.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 for one cycle. Expect pc_write=0, if_id_write=0, id_ex_flush=1 that cycle, then normal operation. Repeat with ex_rd=0: expect no stall.
- Redirect over load-use: lu condition plus branch_taken=1 in the same cycle. Expect pc_write=1, if_id_flush=1, id_ex_flush=1, flush_cnt=1 (macro on).
- Memory wait: imem_ready=0 for 3 cycles from RUN. Expect state MEM_WAIT, pc_write=0, if_id_flush=1 each cycle. imem_ready=1 returns to RUN with pc_write=1; stall_cnt=3 (macro on).
- Watchdog: TIMEOUT=4, imem_ready held 0. Expect fetch_timeout=1 after the 4th wait cycle, still 1 after imem_ready returns, cleared only by rst.
- Reset mid-wait: rst pulsed during MEM_WAIT. Expect BOOT next edge, fetch_timeout=0, counters=0.
